// File: rtl/sensor_display_pkg.sv
// Shared types and helpers for the sensor display selector.
package sensor_display_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE,
    MODE_SUM,
    MODE_SCAN,
    MODE_MAX
  } disp_mode_t;

  // Widest operand sat_add handles; channel width W must not exceed this.
  localparam int unsigned MaxSumW = 32;

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // a + b clamped to 2^w - 1.
  function automatic logic [MaxSumW-1:0] sat_add(input logic [MaxSumW-1:0] a,
                                                 input logic [MaxSumW-1:0] b,
                                                 input int unsigned w);
    logic [MaxSumW:0] s;
    logic [MaxSumW:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ((MaxSumW + 1)'(1) << w) - (MaxSumW + 1)'(1);
    return (s > lim) ? lim[MaxSumW-1:0] : s[MaxSumW-1:0];
  endfunction

endpackage

// File: rtl/bar_graph_encoder.sv
// Maps a W-bit value onto an N_LED bar: level = (value * N_LED) >> W, empty bar for zero.
module bar_graph_encoder #(
  parameter int unsigned W     = 16,
  parameter int unsigned N_LED = 8
) (
  input  logic [W-1:0]             value_i,
  output logic [N_LED-1:0]         bar_o,
  output logic [$clog2(N_LED)-1:0] level_o
);
  localparam int unsigned LvW = $clog2(N_LED);
  localparam int unsigned PW  = W + LvW;

  logic [PW-1:0] prod;

  always_comb begin
    prod    = {{LvW{1'b0}}, value_i} * PW'(N_LED);
    level_o = prod[PW-1:W];
    for (int i = 0; i < N_LED; i++) begin
      bar_o[i] = (value_i != '0) && (LvW'(i) <= level_o);
    end
  end

endmodule

// File: rtl/sensor_display_selector.sv
// N-channel sensor selector with rate-limited display load, auto-scan and bar graph.
// Optional peak-hold dot on the bar: define SENSOR_DISPLAY_PEAK_HOLD_EN.
module sensor_display_selector
  import sensor_display_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned W           = 16,
  parameter int unsigned N_LED       = 8,
  parameter int unsigned UPD_CYCLES  = 2_700_000,
  parameter int unsigned SCAN_CYCLES = 27_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_CH*W-1:0]       ch_value,
  input  logic [1:0]              mode,
  input  logic [$clog2(N_CH)-1:0] ch_sel,
  input  logic                    hold,
  output logic [W-1:0]            value_out,
  output logic [$clog2(N_CH)-1:0] active_ch,
  output logic [N_LED-1:0]        dots,
  output logic [N_LED-1:0]        led_bar,
  output logic                    update
);
  localparam int unsigned ChW   = $clog2(N_CH);
  localparam int unsigned UpdW  = cnt_w(UPD_CYCLES);
  localparam int unsigned ScanW = cnt_w(SCAN_CYCLES);
  localparam int unsigned LvW   = $clog2(N_LED);

  disp_mode_t         mode_e, prev_mode_q, prev_mode_d;
  logic [UpdW-1:0]    upd_cnt_q, upd_cnt_d;
  logic [ScanW-1:0]   scan_cnt_q, scan_cnt_d, scan_cnt_eff;
  logic [ChW-1:0]     scan_idx_q, scan_idx_d, scan_idx_eff;
  logic [W-1:0]       value_q, value_d;
  logic [ChW-1:0]     active_q, active_d;
  logic [N_LED-1:0]   dots_q, dots_d;
  logic               update_q, update_d;
  logic               tick, entering, scan_term, load;
  logic [W-1:0]       ch_arr [N_CH];
  logic [W-1:0]       cand;
  logic [ChW-1:0]     cand_ch;
  logic [MaxSumW-1:0] sum_acc;
  logic               unused_sum;
  logic [N_LED-1:0]   bar;
  logic [LvW-1:0]     level;

  assign mode_e     = disp_mode_t'(mode);
  assign unused_sum = ^sum_acc;

  always_comb begin
    for (int k = 0; k < N_CH; k++) ch_arr[k] = ch_value[k*W +: W];
  end

  // Entering SCAN restarts at channel 0 already in the entry cycle.
  always_comb begin
    tick         = (upd_cnt_q == UpdW'(UPD_CYCLES - 1));
    upd_cnt_d    = tick ? '0 : upd_cnt_q + 1'b1;
    entering     = (mode_e == MODE_SCAN) && (prev_mode_q != MODE_SCAN);
    scan_cnt_eff = entering ? '0 : scan_cnt_q;
    scan_idx_eff = entering ? '0 : scan_idx_q;
    scan_term    = (scan_cnt_eff == ScanW'(SCAN_CYCLES - 1));
    scan_cnt_d   = scan_cnt_q;
    scan_idx_d   = scan_idx_q;
    if (mode_e == MODE_SCAN) begin
      scan_cnt_d = scan_term ? '0 : scan_cnt_eff + 1'b1;
      if (scan_term) begin
        scan_idx_d = (scan_idx_eff == ChW'(N_CH - 1)) ? '0 : scan_idx_eff + 1'b1;
      end else begin
        scan_idx_d = scan_idx_eff;
      end
    end
    prev_mode_d = mode_e;
  end

  always_comb begin
    sum_acc = '0;
    cand    = '0;
    cand_ch = '0;
    case (mode_e)
      MODE_SINGLE: begin
        if (32'(ch_sel) < N_CH) begin
          cand    = ch_arr[ch_sel];
          cand_ch = ch_sel;
        end
      end
      MODE_SUM: begin
        for (int k = 0; k < N_CH; k++) sum_acc = sat_add(sum_acc, MaxSumW'(ch_arr[k]), W);
        cand = sum_acc[W-1:0];
      end
      MODE_SCAN: begin
        cand    = ch_arr[scan_idx_eff];
        cand_ch = scan_idx_eff;
      end
      MODE_MAX: begin
        cand = ch_arr[0];
        // Strict compare keeps the lowest index on ties.
        for (int k = 1; k < N_CH; k++) begin
          if (ch_arr[k] > cand) begin
            cand    = ch_arr[k];
            cand_ch = ChW'(k);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    load     = tick && !hold;
    update_d = load;
    value_d  = value_q;
    active_d = active_q;
    dots_d   = dots_q;
    if (load) begin
      value_d  = cand;
      active_d = cand_ch;
      for (int i = 0; i < N_LED; i++) begin
        dots_d[i] = (mode_e != MODE_SUM) && (int'(cand_ch) == i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      upd_cnt_q   <= '0;
      scan_cnt_q  <= '0;
      scan_idx_q  <= '0;
      prev_mode_q <= MODE_SINGLE;
      value_q     <= '0;
      active_q    <= '0;
      dots_q      <= '0;
      update_q    <= 1'b0;
    end else begin
      upd_cnt_q   <= upd_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      prev_mode_q <= prev_mode_d;
      value_q     <= value_d;
      active_q    <= active_d;
      dots_q      <= dots_d;
      update_q    <= update_d;
    end
  end

  bar_graph_encoder #(
    .W     (W),
    .N_LED (N_LED)
  ) u_bar (
    .value_i (value_q),
    .bar_o   (bar),
    .level_o (level)
  );

`ifdef SENSOR_DISPLAY_PEAK_HOLD_EN
  logic [LvW-1:0]   cand_level, peak_q, peak_d;
  logic             peak_vld_q, peak_vld_d;
  logic [N_LED-1:0] unused_cand_bar, peak_dot;

  bar_graph_encoder #(
    .W     (W),
    .N_LED (N_LED)
  ) u_cand_bar (
    .value_i (cand),
    .bar_o   (unused_cand_bar),
    .level_o (cand_level)
  );

  // A rising load captures the peak; otherwise each tick walks it down towards LED 0.
  always_comb begin
    peak_d     = peak_q;
    peak_vld_d = peak_vld_q;
    if (mode_e != prev_mode_q) begin
      peak_d     = '0;
      peak_vld_d = 1'b0;
    end else if (load && (cand != '0) && (!peak_vld_q || (cand_level > peak_q))) begin
      peak_d     = cand_level;
      peak_vld_d = 1'b1;
    end else if (tick && peak_vld_q) begin
      if (peak_q != '0) begin
        peak_d = peak_q - 1'b1;
      end else if (level == '0) begin
        peak_vld_d = 1'b0;
      end
    end
    for (int i = 0; i < N_LED; i++) peak_dot[i] = peak_vld_q && (int'(peak_q) == i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      peak_q     <= '0;
      peak_vld_q <= 1'b0;
    end else begin
      peak_q     <= peak_d;
      peak_vld_q <= peak_vld_d;
    end
  end

  assign led_bar = bar | peak_dot;
`else
  logic unused_level;
  assign unused_level = ^level;
  assign led_bar      = bar;
`endif

  assign value_out = value_q;
  assign active_ch = active_q;
  assign dots      = dots_q;
  assign update    = update_q;

endmodule
